// File: rtl/ascon_state_bank_if.sv
// Request/response bundle between the ASCON control FSM/datapath and the
// multi-context state bank.
interface ascon_state_bank_if #(
  parameter int W_WORD   = 64,
  parameter int NB_WORDS = 5,
  parameter int NB_CTX   = 4
);
  localparam int CTX_W = (NB_CTX > 1) ? $clog2(NB_CTX) : 1;
  localparam int CNT_W = $clog2(NB_CTX + 1);

  logic                         wr_en_i;
  logic [CTX_W-1:0]             wr_ctx_i;
  logic [NB_WORDS-1:0]          wr_mask_i;
  logic                         wr_mode_i;
  logic [NB_WORDS*W_WORD-1:0]   state_i;
  logic                         clr_en_i;
  logic [CTX_W-1:0]             clr_ctx_i;
  logic                         rd_en_i;
  logic [CTX_W-1:0]             rd_ctx_i;
  logic                         inj_par_i;
  logic [NB_WORDS*W_WORD-1:0]   state_o;
  logic                         rd_valid_o;
  logic                         rd_miss_o;
  logic                         par_err_o;
  logic [NB_CTX-1:0]            ctx_valid_o;
  logic [CNT_W-1:0]             nb_valid_o;

  modport master (
    output wr_en_i, wr_ctx_i, wr_mask_i, wr_mode_i, state_i,
           clr_en_i, clr_ctx_i, rd_en_i, rd_ctx_i, inj_par_i,
    input  state_o, rd_valid_o, rd_miss_o, par_err_o, ctx_valid_o, nb_valid_o
  );

  modport slave (
    input  wr_en_i, wr_ctx_i, wr_mask_i, wr_mode_i, state_i,
           clr_en_i, clr_ctx_i, rd_en_i, rd_ctx_i, inj_par_i,
    output state_o, rd_valid_o, rd_miss_o, par_err_o, ctx_valid_o, nb_valid_o
  );
endinterface

// File: rtl/ascon_state_bank.sv
// Multi-context ASCON permutation state bank with masked load/XOR-absorb,
// clear and registered read-back. Optional word parity: ASCON_STATE_PARITY_EN.
module ascon_state_ctx #(
  parameter int W_WORD   = 64,
  parameter int NB_WORDS = 5
) (
  input  logic                             clock_i,
  input  logic                             resetb_i,
  input  logic                             wr_sel,
  input  logic                             clr_sel,
  input  logic [NB_WORDS-1:0]              wr_mask,
  input  logic                             wr_mode,
  input  logic                             inj_par,
  input  logic [NB_WORDS-1:0][W_WORD-1:0]  wdata,
  output logic [NB_WORDS-1:0][W_WORD-1:0]  words,
  output logic                             valid,
  output logic                             par_err
);
  logic [NB_WORDS-1:0][W_WORD-1:0] nxt;

  always_comb begin
    nxt = '0;
    for (int i = 0; i < NB_WORDS; i++)
      nxt[i] = wr_mode ? (words[i] ^ wdata[i]) : wdata[i];
  end

  // clear has priority: the bank already masks wr_sel, this keeps the slot safe standalone
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      words <= '0;
      valid <= 1'b0;
    end else if (clr_sel) begin
      words <= '0;
      valid <= 1'b0;
    end else if (wr_sel) begin
      valid <= 1'b1;
      for (int i = 0; i < NB_WORDS; i++)
        if (wr_mask[i]) words[i] <= nxt[i];
    end
  end

`ifdef ASCON_STATE_PARITY_EN
  logic [NB_WORDS-1:0] par;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i)    par <= '0;
    else if (clr_sel) par <= '0;
    else if (wr_sel) begin
      for (int i = 0; i < NB_WORDS; i++)
        if (wr_mask[i]) par[i] <= (^nxt[i]) ^ inj_par;
    end
  end

  always_comb begin
    par_err = 1'b0;
    for (int i = 0; i < NB_WORDS; i++)
      par_err = par_err | ((^words[i]) ^ par[i]);
  end
`else
  logic unused_inj;
  assign unused_inj = inj_par;
  assign par_err    = 1'b0;
`endif
endmodule

module ascon_state_bank #(
  parameter int W_WORD   = 64,
  parameter int NB_WORDS = 5,
  parameter int NB_CTX   = 4
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  ascon_state_bank_if.slave bus
);
  localparam int CNT_W = $clog2(NB_CTX + 1);
  typedef logic [NB_WORDS-1:0][W_WORD-1:0] words_t;

  words_t              wdata;
  words_t              ctx_words [NB_CTX];
  logic [NB_CTX-1:0]   wr_sel, clr_sel, ctx_valid, ctx_perr;

  // word 0 lives at the MSBs of the flat bus
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NB_WORDS; i++)
      wdata[i] = bus.state_i[W_WORD*(NB_WORDS-i)-1 -: W_WORD];
  end

  // out-of-range indices match no slot, so they are dropped here
  for (genvar c = 0; c < NB_CTX; c++) begin : g_ctx
    assign clr_sel[c] = bus.clr_en_i && (int'(bus.clr_ctx_i) == c);
    assign wr_sel[c]  = bus.wr_en_i && (int'(bus.wr_ctx_i) == c) && !clr_sel[c];

    ascon_state_ctx #(.W_WORD(W_WORD), .NB_WORDS(NB_WORDS)) u_ctx (
      .clock_i  (clock_i),
      .resetb_i (resetb_i),
      .wr_sel   (wr_sel[c]),
      .clr_sel  (clr_sel[c]),
      .wr_mask  (bus.wr_mask_i),
      .wr_mode  (bus.wr_mode_i),
      .inj_par  (bus.inj_par_i),
      .wdata    (wdata),
      .words    (ctx_words[c]),
      .valid    (ctx_valid[c]),
      .par_err  (ctx_perr[c])
    );
  end

  logic                       rd_hit, rd_vsel, rd_psel;
  logic [NB_WORDS*W_WORD-1:0] rd_flat;
  logic [CNT_W-1:0]           cnt;

  always_comb begin
    rd_hit  = 1'b0;
    rd_vsel = 1'b0;
    rd_psel = 1'b0;
    rd_flat = '0;
    for (int c = 0; c < NB_CTX; c++) begin
      if (int'(bus.rd_ctx_i) == c) begin
        rd_hit  = 1'b1;
        rd_vsel = ctx_valid[c];
        rd_psel = ctx_perr[c];
        for (int i = 0; i < NB_WORDS; i++)
          rd_flat[W_WORD*(NB_WORDS-i)-1 -: W_WORD] = ctx_words[c][i];
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int c = 0; c < NB_CTX; c++)
      cnt = cnt + CNT_W'(ctx_valid[c]);
  end

  // state_o is only updated by a read; the flags are cleared between reads
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      bus.state_o    <= '0;
      bus.rd_valid_o <= 1'b0;
      bus.rd_miss_o  <= 1'b0;
      bus.par_err_o  <= 1'b0;
    end else if (bus.rd_en_i) begin
      bus.state_o    <= rd_flat;
      bus.rd_valid_o <= 1'b1;
      bus.rd_miss_o  <= !(rd_hit && rd_vsel);
      bus.par_err_o  <= rd_hit && rd_psel;
    end else begin
      bus.rd_valid_o <= 1'b0;
      bus.rd_miss_o  <= 1'b0;
      bus.par_err_o  <= 1'b0;
    end
  end

  assign bus.ctx_valid_o = ctx_valid;
  assign bus.nb_valid_o  = cnt;
endmodule

// File: tb/tb_ascon_state_bank.sv
// Randomised and directed checks of ascon_state_bank against a word-array
// reference model (3 contexts so that index 3 is out of range).
module tb_ascon_state_bank;
  localparam int W  = 64;
  localparam int NW = 5;
  localparam int NC = 3;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  ascon_state_bank_if #(.W_WORD(W), .NB_WORDS(NW), .NB_CTX(NC)) bus ();
  ascon_state_bank #(.W_WORD(W), .NB_WORDS(NW), .NB_CTX(NC)) dut (
    .clock_i (clk),
    .resetb_i(rstb),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0]    m_w   [NC][NW];
  bit              m_v   [NC];
  bit              m_bad [NC][NW];
  logic [NW*W-1:0] exp_state;
  bit              exp_valid, exp_miss, exp_perr;

  function automatic logic [W-1:0] word_of(input logic [NW*W-1:0] d, input int i);
    return d[W*(NW-i)-1 -: W];
  endfunction

  function automatic logic [NW*W-1:0] pack_ctx(input int c);
    logic [NW*W-1:0] r = '0;
    for (int i = 0; i < NW; i++) r[W*(NW-i)-1 -: W] = m_w[c][i];
    return r;
  endfunction

  function automatic logic [NC-1:0] m_valid_vec();
    logic [NC-1:0] r = '0;
    for (int c = 0; c < NC; c++) r[c] = m_v[c];
    return r;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int c = 0; c < NC; c++) n += int'(m_v[c]);
    return n;
  endfunction

  function automatic logic [NW*W-1:0] rnd320();
    logic [NW*W-1:0] r;
    for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_v[c] = 0;
      for (int i = 0; i < NW; i++) begin m_w[c][i] = '0; m_bad[c][i] = 0; end
    end
    exp_state = '0;
    exp_valid = 0;
  endtask

  task automatic idle_inputs();
    bus.wr_en_i = 0; bus.wr_ctx_i = '0; bus.wr_mask_i = '0; bus.wr_mode_i = 0;
    bus.state_i = '0; bus.clr_en_i = 0; bus.clr_ctx_i = '0; bus.rd_en_i = 0;
    bus.rd_ctx_i = '0; bus.inj_par_i = 0;
  endtask

  // One clock: drive inputs, predict from the pre-edge model, update the model.
  task automatic cyc(input bit we, input int wc, input logic [NW-1:0] wm, input bit wx,
                     input logic [NW*W-1:0] wd, input bit inj, input bit ce, input int cc,
                     input bit re, input int rc);
    bus.wr_en_i = we; bus.wr_ctx_i = 2'(wc); bus.wr_mask_i = wm; bus.wr_mode_i = wx;
    bus.state_i = wd; bus.inj_par_i = inj; bus.clr_en_i = ce; bus.clr_ctx_i = 2'(cc);
    bus.rd_en_i = re; bus.rd_ctx_i = 2'(rc);
    exp_valid = re;
    if (re) begin
      if (rc < NC) begin
        exp_state = pack_ctx(rc);
        exp_miss  = !m_v[rc];
        exp_perr  = 0;
`ifdef ASCON_STATE_PARITY_EN
        for (int i = 0; i < NW; i++) exp_perr |= m_bad[rc][i];
`endif
      end else begin
        exp_state = '0; exp_miss = 1; exp_perr = 0;
      end
    end
    if (we && wc < NC && !(ce && cc == wc)) begin
      m_v[wc] = 1;
      for (int i = 0; i < NW; i++)
        if (wm[i]) begin
          m_w[wc][i]   = wx ? (m_w[wc][i] ^ word_of(wd, i)) : word_of(wd, i);
          m_bad[wc][i] = inj;
        end
    end
    if (ce && cc < NC) begin
      m_v[cc] = 0;
      for (int i = 0; i < NW; i++) begin m_w[cc][i] = '0; m_bad[cc][i] = 0; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstb = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.state_o !== '0) begin errors++; $display("FAIL reset_state got %h want 0", bus.state_o); end
    checks++; if ({bus.rd_valid_o, bus.rd_miss_o, bus.par_err_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bus.rd_valid_o, bus.rd_miss_o, bus.par_err_o}); end
    checks++; if (bus.ctx_valid_o !== 3'b000 || bus.nb_valid_o !== 2'd0) begin errors++; $display("FAIL reset_valid got %b/%0d want 000/0", bus.ctx_valid_o, bus.nb_valid_o); end
    rstb = 1;
    cyc(0, 0, '0, 0, '0, 0, 0, 0, 1, 2);
    checks++; if (bus.state_o !== '0 || bus.rd_valid_o !== 1'b1 || bus.rd_miss_o !== 1'b1 || bus.nb_valid_o !== 2'd0)
      begin errors++; $display("FAIL reset_read got v%b m%b n%0d s%h want v1 m1 n0 s0", bus.rd_valid_o, bus.rd_miss_o, bus.nb_valid_o, bus.state_o); end
  endtask

  task automatic test_load_xor();
    logic [NW*W-1:0] d, want;
    d = {64'h0123_4567_89AB_CDEF, 64'h1, 64'h2, 64'h3, 64'h4};
    cyc(1, 1, 5'b11111, 0, d, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, '0, 0, 0, 0, 1, 1);
    checks++; if (bus.state_o !== d || bus.rd_miss_o !== 1'b0 || bus.rd_valid_o !== 1'b1)
      begin errors++; $display("FAIL load_read got %h m%b want %h m0", bus.state_o, bus.rd_miss_o, d); end
    checks++; if (bus.ctx_valid_o !== 3'b010 || bus.nb_valid_o !== 2'd1)
      begin errors++; $display("FAIL load_valid got %b/%0d want 010/1", bus.ctx_valid_o, bus.nb_valid_o); end
    // word 0 is selected by mask bit 0
    cyc(1, 1, 5'b00001, 1, {64'hFFFF_FFFF_FFFF_FFFF, 256'h0}, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, '0, 0, 0, 0, 1, 1);
    want = {64'hFEDC_BA98_7654_3210, 64'h1, 64'h2, 64'h3, 64'h4};
    checks++; if (bus.state_o !== want) begin errors++; $display("FAIL xor_read got %h want %h", bus.state_o, want); end
    // unmasked words hold, masked load replaces only word 3
    cyc(1, 1, 5'b01000, 0, {192'h0, 64'hAA, 64'h0}, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, '0, 0, 0, 0, 1, 1);
    want = {64'hFEDC_BA98_7654_3210, 64'h1, 64'h2, 64'hAA, 64'h4};
    checks++; if (bus.state_o !== want) begin errors++; $display("FAIL mask_read got %h want %h", bus.state_o, want); end
    cyc(0, 0, '0, 0, '0, 0, 0, 0, 0, 0);
    checks++; if (bus.rd_valid_o !== 1'b0 || bus.state_o !== want)
      begin errors++; $display("FAIL hold got v%b %h want v0 %h", bus.rd_valid_o, bus.state_o, want); end
  endtask

  task automatic test_clear_collide();
    logic [NW*W-1:0] pre;
    pre = pack_ctx(1);
    cyc(1, 1, 5'b11111, 0, rnd320(), 0, 1, 1, 1, 1);
    checks++; if (bus.state_o !== pre || bus.rd_miss_o !== 1'b0)
      begin errors++; $display("FAIL clr_pre got %h m%b want %h m0", bus.state_o, bus.rd_miss_o, pre); end
    cyc(0, 0, '0, 0, '0, 0, 0, 0, 1, 1);
    checks++; if (bus.state_o !== '0 || bus.rd_miss_o !== 1'b1 || bus.nb_valid_o !== 2'd0)
      begin errors++; $display("FAIL clr_post got %h m%b n%0d want 0 m1 n0", bus.state_o, bus.rd_miss_o, bus.nb_valid_o); end
    // different contexts: both act
    cyc(1, 2, 5'b00000, 0, '0, 0, 0, 0, 0, 0);
    cyc(1, 0, 5'b11111, 0, rnd320(), 0, 1, 2, 0, 0);
    checks++; if (bus.ctx_valid_o !== 3'b001 || bus.nb_valid_o !== 2'd1)
      begin errors++; $display("FAIL clr_diff got %b/%0d want 001/1", bus.ctx_valid_o, bus.nb_valid_o); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] nb0;
    nb0 = bus.nb_valid_o;
    cyc(1, 3, 5'b11111, 0, rnd320(), 0, 0, 0, 0, 0);
    checks++; if (bus.nb_valid_o !== nb0 || bus.ctx_valid_o !== m_valid_vec())
      begin errors++; $display("FAIL oor_write got %0d/%b want %0d/%b", bus.nb_valid_o, bus.ctx_valid_o, nb0, m_valid_vec()); end
    cyc(0, 0, '0, 0, '0, 0, 1, 3, 1, 3);
    checks++; if (bus.state_o !== '0 || bus.rd_miss_o !== 1'b1 || bus.rd_valid_o !== 1'b1 || bus.par_err_o !== 1'b0)
      begin errors++; $display("FAIL oor_read got %h v%b m%b p%b want 0 v1 m1 p0", bus.state_o, bus.rd_valid_o, bus.rd_miss_o, bus.par_err_o); end
    checks++; if (bus.ctx_valid_o !== m_valid_vec())
      begin errors++; $display("FAIL oor_clear got %b want %b", bus.ctx_valid_o, m_valid_vec()); end
  endtask

  task automatic test_parity();
    cyc(1, 0, 5'b00100, 0, rnd320(), 1, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, '0, 0, 0, 0, 1, 0);
    checks++; if (bus.par_err_o !== exp_perr) begin errors++; $display("FAIL par_inj got %b want %b", bus.par_err_o, exp_perr); end
`ifdef ASCON_STATE_PARITY_EN
    checks++; if (bus.par_err_o !== 1'b1) begin errors++; $display("FAIL par_inj_const got %b want 1", bus.par_err_o); end
`endif
    cyc(1, 0, 5'b00100, 1, rnd320(), 0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, '0, 0, 0, 0, 1, 0);
    checks++; if (bus.par_err_o !== 1'b0) begin errors++; $display("FAIL par_clean got %b want 0", bus.par_err_o); end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 3), 5'($urandom()), $urandom_range(0, 1), rnd320(),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), $urandom_range(0, 3),
          ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
      checks++; if (bus.rd_valid_o !== exp_valid || bus.state_o !== exp_state)
        begin errors++; $display("FAIL rnd_data[%0d] got v%b %h want v%b %h", n, bus.rd_valid_o, bus.state_o, exp_valid, exp_state); end
      if (exp_valid) begin
        checks++; if (bus.rd_miss_o !== exp_miss || bus.par_err_o !== exp_perr)
          begin errors++; $display("FAIL rnd_flags[%0d] got m%b p%b want m%b p%b", n, bus.rd_miss_o, bus.par_err_o, exp_miss, exp_perr); end
      end
      checks++; if (bus.ctx_valid_o !== m_valid_vec() || bus.nb_valid_o !== 2'(m_count()))
        begin errors++; $display("FAIL rnd_valid[%0d] got %b/%0d want %b/%0d", n, bus.ctx_valid_o, bus.nb_valid_o, m_valid_vec(), m_count()); end
    end
  endtask

  task automatic test_reset_midflight();
    cyc(1, 0, 5'b11111, 0, rnd320(), 0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, '0, 0, 0, 0, 1, 0);
    checks++; if (bus.rd_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre got v%b want v1", bus.rd_valid_o); end
    bus.rd_en_i = 1;
    #2 rstb = 0;
    model_reset();
    #1;
    checks++; if (bus.rd_valid_o !== 1'b0 || bus.state_o !== '0 || bus.ctx_valid_o !== 3'b000 || bus.nb_valid_o !== 2'd0)
      begin errors++; $display("FAIL mid_async got v%b n%0d want v0 n0", bus.rd_valid_o, bus.nb_valid_o); end
    @(posedge clk); #1;
    checks++; if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL mid_held got v%b want v0", bus.rd_valid_o); end
    idle_inputs();
    rstb = 1;
    cyc(0, 0, '0, 0, '0, 0, 0, 0, 0, 0);
    checks++; if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL mid_release got v%b want v0", bus.rd_valid_o); end
    cyc(0, 0, '0, 0, '0, 0, 0, 0, 1, 0);
    checks++; if (bus.rd_valid_o !== 1'b1 || bus.rd_miss_o !== 1'b1 || bus.state_o !== '0)
      begin errors++; $display("FAIL mid_read got v%b m%b want v1 m1", bus.rd_valid_o, bus.rd_miss_o); end
  endtask

  initial begin
    test_reset();
    test_load_xor();
    test_clear_collide();
    test_out_of_range();
    test_parity();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
